// File: rtl/alu_stage_if.sv
// Operand, control and status bundle between the GPR group / sequencer and alu_stage.
// The shared MainBus stays a plain inout on alu_stage because it has several drivers.
interface alu_stage_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] LHSBus;
  logic [WIDTH-1:0] RHSBus;
  logic [3:0]       op;
  logic             op_valid;
  logic             stall;
  logic             a_main_n;
  logic [3:0]       flags;
  logic             busy;
  logic             res_valid;

  modport master (
    output LHSBus, RHSBus, op, op_valid, stall, a_main_n,
    input  flags, busy, res_valid
  );

  modport slave (
    input  LHSBus, RHSBus, op, op_valid, stall, a_main_n,
    output flags, busy, res_valid
  );
endinterface

// File: rtl/alu_stage.sv
// Single-issue ALU stage: one-cycle logic/arithmetic ops, an 8-step shift-add multiplier,
// registered {C,Z,V,N} flags and a tri-state driver of the result register onto MainBus.
module alu_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_stage_if.slave       bus,
  inout  wire  [WIDTH-1:0] MainBus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] result_r;
  logic [3:0]       flags_r;
  logic             res_valid_r;

  logic             accept_s;
  logic [WIDTH-1:0] arith_b_s;
  logic             arith_cin_s;
  logic             arith_sub_s;
  logic [WIDTH:0]   arith_sum_s;
  logic             arith_v_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;
  logic [WIDTH:0]   step_sum_s;
  logic [WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0] mplier_step_s;

  // Packs a result and its carry/overflow into {C,Z,V,N}.
  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res,
                                            input logic c, input logic v);
    pack_flags = {c, (res == {WIDTH{1'b0}}), v, res[WIDTH-1]};
  endfunction

  assign accept_s = bus.op_valid && !bus.stall && (state_r == IDLE);

  // Operand selection for the shared adder/subtractor.
  always_comb begin
    arith_b_s   = bus.RHSBus;
    arith_cin_s = 1'b0;
    arith_sub_s = 1'b0;
    case (bus.op)
      OP_ADC: arith_cin_s = flags_r[3];
      OP_SUB: arith_sub_s = 1'b1;
      OP_SBB: begin
        arith_sub_s = 1'b1;
        arith_cin_s = flags_r[3];
      end
      OP_INC: arith_b_s = {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: begin
        arith_sub_s = 1'b1;
        arith_b_s   = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      default: arith_sub_s = 1'b0;
    endcase
  end

  // Bit WIDTH of the extended sum is the carry-out when adding and the borrow when subtracting.
  always_comb begin
    if (arith_sub_s) begin
      arith_sum_s = {1'b0, bus.LHSBus} - {1'b0, arith_b_s} - {{WIDTH{1'b0}}, arith_cin_s};
      arith_v_s   = (bus.LHSBus[WIDTH-1] != arith_b_s[WIDTH-1]) &&
                    (arith_sum_s[WIDTH-1] != bus.LHSBus[WIDTH-1]);
    end else begin
      arith_sum_s = {1'b0, bus.LHSBus} + {1'b0, arith_b_s} + {{WIDTH{1'b0}}, arith_cin_s};
      arith_v_s   = (bus.LHSBus[WIDTH-1] == arith_b_s[WIDTH-1]) &&
                    (arith_sum_s[WIDTH-1] != bus.LHSBus[WIDTH-1]);
    end
  end

  // Single-cycle result and carry/overflow for every op except MUL.
  always_comb begin
    alu_res_s = bus.LHSBus;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC: begin
        alu_res_s = arith_sum_s[WIDTH-1:0];
        alu_c_s   = arith_sum_s[WIDTH];
        alu_v_s   = arith_v_s;
      end
      OP_AND: alu_res_s = bus.LHSBus & bus.RHSBus;
      OP_OR:  alu_res_s = bus.LHSBus | bus.RHSBus;
      OP_XOR: alu_res_s = bus.LHSBus ^ bus.RHSBus;
      OP_NOT: alu_res_s = ~bus.LHSBus;
      OP_SHL: begin
        alu_res_s = {bus.LHSBus[WIDTH-2:0], 1'b0};
        alu_c_s   = bus.LHSBus[WIDTH-1];
      end
      OP_SHR: begin
        alu_res_s = {1'b0, bus.LHSBus[WIDTH-1:1]};
        alu_c_s   = bus.LHSBus[0];
      end
      default: alu_res_s = bus.LHSBus;
    endcase
  end

  // One shift-add step: {acc, mplier} holds the growing product, shifted right each step.
  always_comb begin
    if (mplier_r[0]) begin
      step_sum_s = {1'b0, acc_r} + {1'b0, mcand_r};
    end else begin
      step_sum_s = {1'b0, acc_r};
    end
    acc_step_s    = step_sum_s[WIDTH:1];
    mplier_step_s = {step_sum_s[0], mplier_r[WIDTH-1:1]};
  end

  // FSM state register; a stalled edge holds the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (!bus.stall) begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: MUL enters MULT, the last shift-add step returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && (bus.op == OP_MUL)) begin
          state_nxt_s = MULT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MULT: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MULT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath registers: operand capture, multiplier steps, result, flags and the valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      flags_r     <= 4'b0000;
      res_valid_r <= 1'b0;
    end else if (!bus.stall) begin
      res_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && (bus.op == OP_MUL)) begin
            mcand_r  <= bus.LHSBus;
            mplier_r <= bus.RHSBus;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end else if (accept_s) begin
            result_r    <= alu_res_s;
            flags_r     <= pack_flags(alu_res_s, alu_c_s, alu_v_s);
            res_valid_r <= 1'b1;
          end
        end
        MULT: begin
          acc_r    <= acc_step_s;
          mplier_r <= mplier_step_s;
          cnt_r    <= cnt_r + CW'(1);
          // Low half is the result; a nonzero high half sets C.
          if (cnt_r == LAST_STEP) begin
            result_r    <= mplier_step_s;
            flags_r     <= pack_flags(mplier_step_s, (acc_step_s != {WIDTH{1'b0}}), 1'b0);
            res_valid_r <= 1'b1;
          end
        end
        default: res_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.flags     = flags_r;
  assign bus.busy      = (state_r == MULT);
  assign bus.res_valid = res_valid_r;
  assign MainBus       = bus.a_main_n ? {WIDTH{1'bz}} : result_r;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed cases plus randomized ops against an integer model.
module tb_alu_stage;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  wire  [W-1:0] main_bus;
  logic         tb_drv_en;
  logic [W-1:0] tb_drv_val;
  int           n_checks = 0;
  int           n_pass = 0;
  logic [3:0]   m_flags;

  alu_stage_if #(.WIDTH(W)) ifc ();

  alu_stage #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc.slave),
    .MainBus (main_bus)
  );

  assign main_bus = tb_drv_en ? tb_drv_val : {W{1'bz}};

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic: returns {C,Z,V,N,result}.
  function automatic logic [11:0] ref_alu(input int op, input int l, input int r, input int cin);
    int full, sfull, sl, sr, b, sb, k, res;
    bit c, v;
    sl = (l > 127) ? l - 256 : l;
    sr = (r > 127) ? r - 256 : r;
    b = r; sb = sr; k = 0; c = 1'b0; v = 1'b0; res = 0;
    if (op == 10 || op == 11) begin b = 1; sb = 1; end
    if (op == 1 || op == 3) k = cin;
    case (op)
      0, 1, 10: begin
        full = l + b + k; sfull = sl + sb + k;
        res = full % 256; c = (full > 255); v = (sfull > 127) || (sfull < -128);
      end
      2, 3, 11: begin
        full = l - b - k; sfull = sl - sb - k;
        res = (full + 512) % 256; c = (full < 0); v = (sfull > 127) || (sfull < -128);
      end
      4: res = l & r;
      5: res = l | r;
      6: res = l ^ r;
      7: res = 255 - l;
      8: begin res = (l * 2) % 256; c = (l > 127); end
      9: begin res = l / 2; c = ((l % 2) == 1); end
      12: begin full = l * r; res = full % 256; c = (full > 255); end
      default: res = l;
    endcase
    return {c, (res == 0), v, (res > 127), 8'(res)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input int op, input int l, input int r);
    ifc.op       = 4'(op);
    ifc.LHSBus   = 8'(l);
    ifc.RHSBus   = 8'(r);
    ifc.op_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ifc.stall = 1'b1; drive_op(0, 8'h11, 8'h22);
    tick(); tick();
    n_checks++; if (ifc.flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", ifc.flags); else n_pass++;
    n_checks++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifc.busy); else n_pass++;
    n_checks++; if (ifc.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", ifc.res_valid); else n_pass++;
    n_checks++; if (main_bus !== 8'h00) $display("FAIL reset_result: got %h want 00", main_bus); else n_pass++;
    rst_n = 1'b1; ifc.stall = 1'b0; ifc.op_valid = 1'b0;
    tick();
    m_flags = 4'b0000;
  endtask

  task automatic test_random();
    logic [11:0] exp;
    int op, l, r, lat;
    for (int i = 0; i < 80; i++) begin
      op = int'($urandom_range(0, 15)); l = int'($urandom_range(0, 255)); r = int'($urandom_range(0, 255));
      exp = ref_alu(op, l, r, int'(m_flags[3]));
      drive_op(op, l, r);
      tick();
      if (op == 12) begin
        ifc.op_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
          tick();
          if (ifc.res_valid === 1'b1) lat = k;
        end
        n_checks++; if (lat != 8) $display("FAIL rand_mul_latency: got %0d want 8", lat); else n_pass++;
      end else begin
        n_checks++; if (ifc.res_valid !== 1'b1) $display("FAIL rand_res_valid op=%0d: got %b want 1", op, ifc.res_valid); else n_pass++;
      end
      n_checks++; if (main_bus !== exp[7:0]) $display("FAIL rand_result op=%0d l=%h r=%h: got %h want %h", op, l, r, main_bus, exp[7:0]); else n_pass++;
      n_checks++; if (ifc.flags !== exp[11:8]) $display("FAIL rand_flags op=%0d l=%h r=%h: got %b want %b", op, l, r, ifc.flags, exp[11:8]); else n_pass++;
      m_flags = exp[11:8];
      if ($urandom_range(0, 3) == 0) begin
        ifc.op_valid = 1'b0;
        tick();
        n_checks++; if (ifc.res_valid !== 1'b0) $display("FAIL rand_idle_pulse: got %b want 0", ifc.res_valid); else n_pass++;
      end
    end
    ifc.op_valid = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain();
    drive_op(0, 8'h7F, 8'h01); tick();
    n_checks++; if (main_bus !== 8'h80 || ifc.flags !== 4'b0011) $display("FAIL add_7f_01: got %h/%b want 80/0011", main_bus, ifc.flags); else n_pass++;
    n_checks++; if (ifc.res_valid !== 1'b1) $display("FAIL add_pulse: got %b want 1", ifc.res_valid); else n_pass++;
    ifc.op_valid = 1'b0; tick();
    n_checks++; if (ifc.res_valid !== 1'b0 || main_bus !== 8'h80) $display("FAIL add_pulse_end: got %b/%h want 0/80", ifc.res_valid, main_bus); else n_pass++;
    drive_op(2, 8'h05, 8'h05); tick();
    n_checks++; if (main_bus !== 8'h00 || ifc.flags !== 4'b0100) $display("FAIL sub_05_05: got %h/%b want 00/0100", main_bus, ifc.flags); else n_pass++;
    drive_op(3, 8'h00, 8'h01); tick();
    n_checks++; if (main_bus !== 8'hFF || ifc.flags !== 4'b1001) $display("FAIL sbb_00_01: got %h/%b want ff/1001", main_bus, ifc.flags); else n_pass++;
    drive_op(1, 8'h01, 8'h01); tick();
    n_checks++; if (main_bus !== 8'h03 || ifc.flags !== 4'b0000) $display("FAIL adc_01_01: got %h/%b want 03/0000", main_bus, ifc.flags); else n_pass++;
    drive_op(10, 8'hFF, 8'h00); tick();
    n_checks++; if (main_bus !== 8'h00 || ifc.flags !== 4'b1100) $display("FAIL inc_ff: got %h/%b want 00/1100", main_bus, ifc.flags); else n_pass++;
    drive_op(11, 8'h00, 8'h00); tick();
    n_checks++; if (main_bus !== 8'hFF || ifc.flags !== 4'b1001) $display("FAIL dec_00: got %h/%b want ff/1001", main_bus, ifc.flags); else n_pass++;
    ifc.op_valid = 1'b0; tick();
  endtask

  task automatic test_mul();
    int busy_cnt;
    drive_op(12, 8'h0D, 8'h0B); tick();
    ifc.op_valid = 1'b0;
    busy_cnt = 0;
    while (ifc.busy === 1'b1 && busy_cnt < 20) begin busy_cnt++; tick(); end
    n_checks++; if (busy_cnt != 8) $display("FAIL mul_busy_cycles: got %0d want 8", busy_cnt); else n_pass++;
    n_checks++; if (ifc.res_valid !== 1'b1 || main_bus !== 8'h8F || ifc.flags !== 4'b0001) $display("FAIL mul_0d_0b: got %b/%h/%b want 1/8f/0001", ifc.res_valid, main_bus, ifc.flags); else n_pass++;
    drive_op(12, 8'h10, 8'h10); tick();
    ifc.op_valid = 1'b0;
    busy_cnt = 0;
    while (ifc.busy === 1'b1 && busy_cnt < 20) begin
      busy_cnt++;
      if (busy_cnt == 4) begin
        n_checks++; if (main_bus !== 8'h8F) $display("FAIL mul_bus_during_mult: got %h want 8f", main_bus); else n_pass++;
      end
      tick();
    end
    n_checks++; if (main_bus !== 8'h00 || ifc.flags !== 4'b1100) $display("FAIL mul_10_10: got %h/%b want 00/1100", main_bus, ifc.flags); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int early;
    drive_op(12, 8'h03, 8'h05); tick();
    drive_op(0, 8'h20, 8'h01);
    early = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 7 && ifc.res_valid === 1'b1) early++;
      if (k == 8) begin
        n_checks++; if (ifc.res_valid !== 1'b1 || main_bus !== 8'h0F) $display("FAIL b2b_mul_done: got %b/%h want 1/0f", ifc.res_valid, main_bus); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if (ifc.res_valid !== 1'b1 || main_bus !== 8'h21 || ifc.busy !== 1'b0) $display("FAIL b2b_second_op: got %b/%h/%b want 1/21/0", ifc.res_valid, main_bus, ifc.busy); else n_pass++;
      end
    end
    n_checks++; if (early != 0) $display("FAIL b2b_early_pulse: got %0d want 0", early); else n_pass++;
    ifc.op_valid = 1'b0; tick();
  endtask

  task automatic test_stall();
    int done_at, stall_busy_bad;
    drive_op(12, 8'h07, 8'h09); tick();
    ifc.op_valid = 1'b0;
    done_at = 0; stall_busy_bad = 0;
    for (int k = 1; k <= 15; k++) begin
      ifc.stall = (k >= 2 && k <= 4);
      tick();
      if (ifc.stall && ifc.busy !== 1'b1) stall_busy_bad++;
      if (done_at == 0 && ifc.res_valid === 1'b1) done_at = k;
    end
    ifc.stall = 1'b0;
    n_checks++; if (done_at != 11) $display("FAIL stall_mul_completion: got edge N+%0d want N+11", done_at); else n_pass++;
    n_checks++; if (stall_busy_bad != 0) $display("FAIL stall_busy_hold: got %0d bad cycles want 0", stall_busy_bad); else n_pass++;
    n_checks++; if (main_bus !== 8'h3F) $display("FAIL stall_mul_result: got %h want 3f", main_bus); else n_pass++;
    ifc.stall = 1'b1; drive_op(0, 8'h01, 8'h01); tick();
    n_checks++; if (ifc.res_valid !== 1'b0 || main_bus !== 8'h3F) $display("FAIL stall_ignores_op: got %b/%h want 0/3f", ifc.res_valid, main_bus); else n_pass++;
    ifc.stall = 1'b0; tick();
    n_checks++; if (ifc.res_valid !== 1'b1 || main_bus !== 8'h02) $display("FAIL stall_release_accept: got %b/%h want 1/02", ifc.res_valid, main_bus); else n_pass++;
    ifc.op_valid = 1'b0; tick();
  endtask

  task automatic test_reset_mul();
    int pulses;
    drive_op(12, 8'h0D, 8'h0B); tick();
    ifc.op_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    n_checks++; if (ifc.busy !== 1'b0 || ifc.flags !== 4'b0000 || main_bus !== 8'h00 || ifc.res_valid !== 1'b0)
      $display("FAIL reset_mid_mul: got busy=%b flags=%b res=%h rv=%b want 0/0000/00/0", ifc.busy, ifc.flags, main_bus, ifc.res_valid);
    else n_pass++;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (ifc.res_valid === 1'b1) pulses++; end
    n_checks++; if (pulses != 0) $display("FAIL reset_mid_mul_pulse: got %0d want 0", pulses); else n_pass++;
  endtask

  task automatic test_bus();
    drive_op(12, 8'h0D, 8'h0B); tick();
    ifc.op_valid = 1'b0;
    repeat (9) tick();
    n_checks++; if (main_bus !== 8'h8F) $display("FAIL bus_drive: got %h want 8f", main_bus); else n_pass++;
    ifc.a_main_n = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 8'hA5; #1;
    n_checks++; if (main_bus !== 8'hA5) $display("FAIL bus_release_a5: got %h want a5", main_bus); else n_pass++;
    tb_drv_val = 8'h5A; #1;
    n_checks++; if (main_bus !== 8'h5A) $display("FAIL bus_release_5a: got %h want 5a", main_bus); else n_pass++;
    tb_drv_en = 1'b0; ifc.a_main_n = 1'b0; #1;
    n_checks++; if (main_bus !== 8'h8F) $display("FAIL bus_redrive: got %h want 8f", main_bus); else n_pass++;
  endtask

  initial begin
    tb_drv_en = 1'b0; tb_drv_val = 8'h00; m_flags = 4'b0000;
    ifc.a_main_n = 1'b0; ifc.stall = 1'b0; ifc.op_valid = 1'b0;
    ifc.op = 4'd0; ifc.LHSBus = 8'h00; ifc.RHSBus = 8'h00;
    rst_n = 1'b0;
    test_reset();
    test_random();
    test_carry_chain();
    test_mul();
    test_back_to_back();
    test_stall();
    test_reset_mul();
    test_bus();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
